// File: rtl/abe_core_seq_pkg.sv
// Shared types, ALU instruction-field layout and instruction templates for the ABE
// program sequencer.
package abe_core_seq_pkg;

    localparam int unsigned ALU_MAIN_MEM_ADDR_BITS = 6;
    localparam int unsigned ALU_INST_BITS          = 32;

    // Field positions inside the ALU instruction word (LSB of each field).
    localparam int unsigned INDEX_MAIN_WE    = 0;
    localparam int unsigned INDEX_MAIN_WRITE = 1;
    localparam int unsigned INDEX_MAIN_READB = 7;

    typedef logic [ALU_INST_BITS-1:0]          alu_inst_t;
    typedef logic [ALU_MAIN_MEM_ADDR_BITS-1:0] main_addr_t;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StRun    = 3'd2,
        StDrain  = 3'd3,
        StFinish = 3'd4
    } seq_state_e;

    // Load-word template: only the main write enable and write address are set.
    function automatic alu_inst_t load_word_inst(main_addr_t addr);
        alu_inst_t inst;
        inst = '0;
        inst[INDEX_MAIN_WE] = 1'b1;
        inst[INDEX_MAIN_WRITE +: ALU_MAIN_MEM_ADDR_BITS] = addr;
        return inst;
    endfunction

    // Read-word template: only the port-B read address is set.
    function automatic alu_inst_t read_word_inst(main_addr_t addr);
        alu_inst_t inst;
        inst = '0;
        inst[INDEX_MAIN_READB +: ALU_MAIN_MEM_ADDR_BITS] = addr;
        return inst;
    endfunction

endpackage

// File: rtl/abe_core_seq_if.sv
// Host-side bundle of the ABE sequencer: program control, operand load and readout.
interface abe_core_seq_if #(
    parameter int unsigned DAT_BITS = 381,
    parameter int unsigned PC_BITS  = 10
) ();
    import abe_core_seq_pkg::*;

    logic                start;
    logic [PC_BITS-1:0]  prog_base;
    logic [PC_BITS-1:0]  prog_len;
    logic                busy;
    logic                done;

    logic                ld_valid;
    logic                ld_ready;
    main_addr_t          ld_addr;
    logic [DAT_BITS-1:0] ld_data;

    logic                rd_req;
    main_addr_t          rd_addr;
    logic                rd_valid;

    modport master (
        output start, prog_base, prog_len, ld_valid, ld_addr, ld_data, rd_req, rd_addr,
        input  busy, done, ld_ready, rd_valid
    );

    modport slave (
        input  start, prog_base, prog_len, ld_valid, ld_addr, ld_data, rd_req, rd_addr,
        output busy, done, ld_ready, rd_valid
    );

endinterface

// File: rtl/abe_core_seq_pipe.sv
// Fixed-latency register pipe; output equals the input delayed by PIPE_STG cycles.
module abe_core_seq_pipe #(
    parameter int unsigned DAT_BITS = 1,
    parameter int unsigned PIPE_STG = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DAT_BITS-1:0] din,
    output logic [DAT_BITS-1:0] dout
);

    logic [DAT_BITS-1:0] stg_q [PIPE_STG];
    logic [DAT_BITS-1:0] stg_d [PIPE_STG];

    always_comb begin
        stg_d[0] = din;
        for (int unsigned i = 1; i < PIPE_STG; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_STG; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q <= stg_d;
        end
    end

    assign dout = stg_q[PIPE_STG-1];

endmodule

// File: rtl/abe_core_seq.sv
// ABE program sequencer: loads operands, services readouts and streams an instruction-ROM
// program to the ALU, then drains in-flight results before signalling completion.
module abe_core_seq
    import abe_core_seq_pkg::*;
#(
    parameter int unsigned DAT_BITS  = 381,
    parameter int unsigned PC_BITS   = 10,
    parameter int unsigned DRAIN_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    abe_core_seq_if.slave            host,
    output logic [PC_BITS-1:0]       rom_addr,
    input  logic [ALU_INST_BITS-1:0] rom_data,
    output logic                     operate,
    output logic [ALU_INST_BITS-1:0] INST1,
    output logic                     ALU_din_en,
    output logic [DAT_BITS-1:0]      ALU_din
);

    localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    seq_state_e          state_q, state_d;
    logic [PC_BITS-1:0]  pc_q, pc_d;
    logic [PC_BITS-1:0]  len_q, len_d;
    logic [PC_BITS-1:0]  count_q, count_d;
    logic [DrainW-1:0]   drain_q, drain_d;

    alu_inst_t           inst1_q, inst1_d;
    logic                alu_din_en_q, alu_din_en_d;
    logic [DAT_BITS-1:0] alu_din_q, alu_din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                operate_q, operate_d;
    logic                ld_ready_q, ld_ready_d;
    logic [PC_BITS-1:0]  rom_addr_q, rom_addr_d;

    logic                ld_fire;
    logic                rd_fire;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        len_d        = len_q;
        count_d      = count_q;
        drain_d      = drain_q;
        inst1_d      = '0;
        alu_din_en_d = 1'b0;
        alu_din_d    = alu_din_q;
        ld_fire      = 1'b0;
        rd_fire      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (host.ld_valid && ld_ready_q) begin
                    ld_fire      = 1'b1;
                    inst1_d      = load_word_inst(host.ld_addr);
                    alu_din_en_d = 1'b1;
                    alu_din_d    = host.ld_data;
                end else begin
                    // A read may ride along with an accepted start: FETCH issues nothing,
                    // and rd_valid travels through its own pipe independent of the FSM.
                    if (host.rd_req) begin
                        rd_fire = 1'b1;
                        inst1_d = read_word_inst(host.rd_addr);
                    end
                    if (host.start) begin
                        if (host.prog_len == '0) begin
                            state_d = StFinish;
                        end else begin
                            state_d = StFetch;
                            pc_d    = host.prog_base;
                            len_d   = host.prog_len;
                            count_d = '0;
                        end
                    end
                end
            end
            StFetch: begin
                pc_d    = pc_q + PC_BITS'(1);
                state_d = StRun;
            end
            StRun: begin
                inst1_d = rom_data;
                pc_d    = pc_q + PC_BITS'(1);
                count_d = count_q + PC_BITS'(1);
                if (count_d == len_q) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                drain_d = drain_q + DrainW'(1);
                if (drain_q == DrainW'(DRAIN_CYC - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered host/ALU outputs; operate tracks the cycles whose INST1 is being issued.
    always_comb begin
        busy_d     = (state_d != StIdle);
        ld_ready_d = (state_d == StIdle);
        done_d     = (state_q == StFinish);
        operate_d  = (state_q == StRun) || (state_q == StDrain) || ld_fire || rd_fire;
        rom_addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            len_q        <= '0;
            count_q      <= '0;
            drain_q      <= '0;
            inst1_q      <= '0;
            alu_din_en_q <= 1'b0;
            alu_din_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            operate_q    <= 1'b0;
            ld_ready_q   <= 1'b1;
            rom_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            len_q        <= len_d;
            count_q      <= count_d;
            drain_q      <= drain_d;
            inst1_q      <= inst1_d;
            alu_din_en_q <= alu_din_en_d;
            alu_din_q    <= alu_din_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            operate_q    <= operate_d;
            ld_ready_q   <= ld_ready_d;
            rom_addr_q   <= rom_addr_d;
        end
    end

    abe_core_seq_pipe #(
        .DAT_BITS (1),
        .PIPE_STG (2)
    ) u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rd_fire),
        .dout  (host.rd_valid)
    );

    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.ld_ready = ld_ready_q;
    assign rom_addr      = rom_addr_q;
    assign operate       = operate_q;
    assign INST1         = inst1_q;
    assign ALU_din_en    = alu_din_en_q;
    assign ALU_din       = alu_din_q;

endmodule

// File: tb/tb_abe_core_seq.sv
// Directed self-checking bench for abe_core_seq: reset, load, readout, program run,
// zero-length, pc wrap, conflict resolution and reset abort.
module tb_abe_core_seq;
    import abe_core_seq_pkg::*;

    localparam int unsigned DB = 381;
    localparam int unsigned PB = 10;
    localparam int unsigned DC = 64;

    logic                     clk;
    logic                     rst_n;
    logic [PB-1:0]            rom_addr;
    logic [ALU_INST_BITS-1:0] rom_data;
    logic [ALU_INST_BITS-1:0] inst1;
    logic                     operate;
    logic                     din_en;
    logic [DB-1:0]            din;
    logic [ALU_INST_BITS-1:0] rom_mem [1024];

    int checks   = 0;
    int failures = 0;

    abe_core_seq_if #(.DAT_BITS(DB), .PC_BITS(PB)) bus ();

    abe_core_seq #(
        .DAT_BITS  (DB),
        .PC_BITS   (PB),
        .DRAIN_CYC (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (bus),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .operate    (operate),
        .INST1      (inst1),
        .ALU_din_en (din_en),
        .ALU_din    (din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.prog_base = '0;
        bus.prog_len  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (inst1 !== 32'h0) begin failures++; $display("FAIL rst_inst1: got %h want 0", inst1); end
        checks++; if (din_en !== 1'b0) begin failures++; $display("FAIL rst_din_en: got %b want 0", din_en); end
        checks++; if (din !== '0) begin failures++; $display("FAIL rst_din: got %h want 0", din); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", bus.done); end
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
        checks++; if (operate !== 1'b0) begin failures++; $display("FAIL rst_operate: got %b want 0", operate); end
        checks++; if (rom_addr !== '0) begin failures++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL rel_ld_ready: got %b want 1", bus.ld_ready); end
        tick();
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL idle_ld_ready: got %b want 1", bus.ld_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_load();
        logic [ALU_INST_BITS-1:0] exp_inst [3];
        logic [DB-1:0]            exp_dat;
        exp_inst[0] = 32'h0000_000B;
        exp_inst[1] = 32'h0000_000D;
        exp_inst[2] = 32'h0000_000F;
        for (int k = 0; k < 3; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = main_addr_t'(5 + k);
            bus.ld_data  = {8'hA5, 373'(5 + k)};
            exp_dat      = {8'hA5, 373'(5 + k)};
            tick();
            checks++; if (inst1 !== exp_inst[k]) begin failures++; $display("FAIL load_inst%0d: got %h want %h", k, inst1, exp_inst[k]); end
            checks++; if (din_en !== 1'b1) begin failures++; $display("FAIL load_din_en%0d: got %b want 1", k, din_en); end
            checks++; if (din !== exp_dat) begin failures++; $display("FAIL load_din%0d: got %h want %h", k, din, exp_dat); end
            checks++; if (operate !== 1'b1) begin failures++; $display("FAIL load_operate%0d: got %b want 1", k, operate); end
        end
        bus.ld_valid = 1'b0;
        tick();
        checks++; if (inst1 !== 32'h0) begin failures++; $display("FAIL load_after_inst: got %h want 0", inst1); end
        checks++; if (din_en !== 1'b0) begin failures++; $display("FAIL load_after_din_en: got %b want 0", din_en); end
    endtask

    task automatic test_read();
        bus.rd_req  = 1'b1;
        bus.rd_addr = main_addr_t'(9);
        tick();
        bus.rd_req = 1'b0;
        checks++; if (inst1 !== 32'h0000_0480) begin failures++; $display("FAIL read_inst: got %h want 00000480", inst1); end
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL read_rv_c1: got %b want 0", bus.rd_valid); end
        checks++; if (operate !== 1'b1) begin failures++; $display("FAIL read_operate: got %b want 1", operate); end
        tick();
        checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL read_rv_c2: got %b want 1", bus.rd_valid); end
        checks++; if (inst1 !== 32'h0) begin failures++; $display("FAIL read_inst_c2: got %h want 0", inst1); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL read_rv_c3: got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_back_to_back();
        bus.rd_req  = 1'b1;
        bus.rd_addr = main_addr_t'(3);
        tick();
        bus.rd_addr = main_addr_t'(4);
        checks++; if (inst1 !== 32'h0000_0180) begin failures++; $display("FAIL b2b_inst0: got %h want 00000180", inst1); end
        tick();
        bus.rd_req = 1'b0;
        checks++; if (inst1 !== 32'h0000_0200) begin failures++; $display("FAIL b2b_inst1: got %h want 00000200", inst1); end
        checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL b2b_rv1: got %b want 1", bus.rd_valid); end
        tick();
        checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL b2b_rv2: got %b want 1", bus.rd_valid); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_rv3: got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_run();
        int bad_zero = 0;
        int dones    = 0;
        int done_at  = -1;
        bus.prog_base = PB'(10);
        bus.prog_len  = PB'(4);
        bus.start     = 1'b1;
        for (int n = 0; n < int'(DC) + 10; n++) begin
            tick();
            bus.start = (n == 3);  // second start mid-run must be ignored
            if (n == 3) begin
                bus.prog_base = PB'(100);
                bus.prog_len  = PB'(2);
            end
            if (n < 4) begin
                checks++; if (rom_addr !== PB'(10 + n)) begin failures++; $display("FAIL run_rom_addr%0d: got %0d want %0d", n, rom_addr, 10 + n); end
            end
            if (n >= 2 && n < 6) begin
                checks++; if (inst1 !== rom_mem[10 + n - 2]) begin failures++; $display("FAIL run_inst%0d: got %h want %h", n - 2, inst1, rom_mem[10 + n - 2]); end
            end
            if (n >= 6 && n < 6 + int'(DC)) begin
                if (inst1 !== 32'h0 || operate !== 1'b1) bad_zero++;
            end
            if (n == 6 + int'(DC)) begin
                checks++; if (operate !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL run_end: got operate=%b busy=%b want 0 0", operate, bus.busy); end
            end
            if (bus.done === 1'b1) begin
                dones++;
                done_at = n;
            end
        end
        checks++; if (bad_zero != 0) begin failures++; $display("FAIL run_drain: got %0d bad drain cycles want 0", bad_zero); end
        checks++; if (dones != 1) begin failures++; $display("FAIL run_done_count: got %0d want 1", dones); end
        checks++; if (done_at != 6 + int'(DC)) begin failures++; $display("FAIL run_done_cycle: got %0d want %0d", done_at, 6 + int'(DC)); end
        idle_inputs();
    endtask

    task automatic test_zero_len();
        logic [PB-1:0] addr_before;
        addr_before   = rom_addr;
        bus.prog_base = PB'(10);
        bus.prog_len  = '0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL zl_done_c1: got %b want 0", bus.done); end
        checks++; if (inst1 !== 32'h0 || operate !== 1'b0) begin failures++; $display("FAIL zl_issue_c1: got inst=%h op=%b want 0 0", inst1, operate); end
        tick();
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL zl_done_c2: got %b want 1", bus.done); end
        checks++; if (inst1 !== 32'h0 || operate !== 1'b0) begin failures++; $display("FAIL zl_issue_c2: got inst=%h op=%b want 0 0", inst1, operate); end
        checks++; if (rom_addr !== addr_before) begin failures++; $display("FAIL zl_rom_addr: got %0d want %0d", rom_addr, addr_before); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL zl_done_c3: got %b want 0", bus.done); end
    endtask

    task automatic test_wrap();
        logic [PB-1:0] seq [4];
        logic          found;
        seq[0] = PB'(1022);
        seq[1] = PB'(1023);
        seq[2] = PB'(0);
        seq[3] = PB'(1);
        bus.prog_base = PB'(1022);
        bus.prog_len  = PB'(4);
        bus.start     = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            bus.start = 1'b0;
            if (n < 4) begin
                checks++; if (rom_addr !== seq[n]) begin failures++; $display("FAIL wrap_rom_addr%0d: got %0d want %0d", n, rom_addr, seq[n]); end
            end
            if (n >= 2) begin
                checks++; if (inst1 !== rom_mem[seq[n-2]]) begin failures++; $display("FAIL wrap_inst%0d: got %h want %h", n - 2, inst1, rom_mem[seq[n-2]]); end
            end
        end
        found = 1'b0;
        for (int n = 0; n < int'(DC) + 20 && !found; n++) begin
            tick();
            if (bus.done === 1'b1) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL wrap_done: got no done within budget, want one"); end
        tick();
    endtask

    task automatic test_conflict();
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = main_addr_t'(12);
        bus.ld_data   = {8'h3C, 373'(12)};
        bus.rd_req    = 1'b1;
        bus.rd_addr   = main_addr_t'(13);
        bus.prog_base = PB'(10);
        bus.prog_len  = PB'(4);
        bus.start     = 1'b1;
        tick();
        idle_inputs();
        checks++; if (inst1 !== 32'h0000_0019) begin failures++; $display("FAIL conf_inst: got %h want 00000019", inst1); end
        checks++; if (din_en !== 1'b1) begin failures++; $display("FAIL conf_din_en: got %b want 1", din_en); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL conf_busy_c1: got %b want 0", bus.busy); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL conf_rv_c2: got %b want 0", bus.rd_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL conf_busy_c2: got %b want 0", bus.busy); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL conf_rv_c3: got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_read_during_start();
        logic found;
        bus.rd_req    = 1'b1;
        bus.rd_addr   = main_addr_t'(20);
        bus.prog_base = PB'(10);
        bus.prog_len  = PB'(1);
        bus.start     = 1'b1;
        tick();
        idle_inputs();
        checks++; if (inst1 !== 32'h0000_0A00) begin failures++; $display("FAIL rds_inst: got %h want 00000A00", inst1); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rds_busy: got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL rds_rv: got %b want 1", bus.rd_valid); end
        found = 1'b0;
        for (int n = 0; n < int'(DC) + 20 && !found; n++) begin
            tick();
            if (bus.done === 1'b1) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL rds_done: got no done within budget, want one"); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        bus.prog_base = PB'(10);
        bus.prog_len  = PB'(4);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy_now: got %b want 0", bus.busy); end
        checks++; if (inst1 !== 32'h0) begin failures++; $display("FAIL abort_inst_now: got %h want 0", inst1); end
        tick();
        checks++; if (bus.busy !== 1'b0 || inst1 !== 32'h0) begin failures++; $display("FAIL abort_edge: got busy=%b inst=%h want 0 0", bus.busy, inst1); end
        checks++; if (bus.done !== 1'b0 || operate !== 1'b0) begin failures++; $display("FAIL abort_done_op: got done=%b op=%b want 0 0", bus.done, operate); end
        rst_n = 1'b1;
        for (int n = 0; n < int'(DC) + 20; n++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL abort_ld_ready: got %b want 1", bus.ld_ready); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom_mem[i] = 32'h8000_0000 | (32'h5A00_0000 ^ (32'(i) * 32'h0001_0101));
        end
        idle_inputs();
        test_reset();
        test_load();
        test_read();
        test_back_to_back();
        test_run();
        test_zero_len();
        test_wrap();
        test_conflict();
        test_read_during_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
